div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative radix-2 restoring divider implementing the RV32M divide group: DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage. It takes the same operand pair (A = rs1, B = rs2) and returns a result word plus ZF/SF flags with the same meaning as the ALU flags.
- Multi-cycle: uses a start/busy/done handshake so the control unit can stall the PC while a division is in progress.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
- CNT_W, 5, width of the iteration counter; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only when the state is IDLE or DONE.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- A  input  WIDTH  dividend; captured on the accepting edge.
- B  input  WIDTH  divisor; captured on the accepting edge.
- abort  input  1  synchronous cancel of an in-flight division.
- busy  output  1  high while the state is CALC.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle onward.
- result  output  WIDTH  quotient or remainder, held until the next done.
- ZF  output  1  result == 0; registered together with result.
- SF  output  1  result[WIDTH-1]; registered together with result.
- DZ  output  1  divide-by-zero indicator for the last completed operation.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; result=0; ZF=1; SF=0; DZ=0; counter and internal registers cleared. Reset mid-CALC discards the operation and produces no done.
- States:
  - IDLE --start--> CALC, or --start with special case--> DONE.
  - CALC --counter==WIDTH-1--> DONE.
  - CALC --abort--> IDLE.
  - DONE --start--> same rule as IDLE; DONE --no start--> IDLE.
- Accept edge k, normal case:
  - Latch op.
  - Signed ops (DIV/REM): latch |A| and |B|, and record quotient sign = A[msb]^B[msb] and remainder sign = A[msb].
  - Unsigned ops: latch A and B as given.
  - Clear partial remainder; counter=0; state=CALC.
- CALC step, once per edge:
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor from the upper part; if non-negative, keep the difference and set the quotient LSB to 1, otherwise set it to 0.
  - counter++.
- Completion:
  - The edge that performs iteration WIDTH-1 (edge k+WIDTH) also loads result and flags. It applies sign correction (negate quotient or remainder per the recorded signs) and selects quotient (op[1]=0) or remainder (op[1]=1).
  - state=DONE; done=1 for that one cycle.
  - Latency: done is high in the cycle after edge k+32 for WIDTH=32.
- Special cases, resolved at the accept edge: state goes directly to DONE, and done is high in the cycle after edge k.
  - B==0: quotient=all ones and remainder=A for both signed and unsigned ops; DZ=1.
  - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): quotient=0x80000000, remainder=0; DZ=0.
  - All other operations leave DZ=0 at completion.
- Handshake:
  - start while busy=1 is ignored; no queueing.
  - start in the DONE cycle is accepted, giving back-to-back operation; done then drops in the following cycle unless the new operation is a special case, which yields consecutive done pulses.
  - Operands need be stable only on the accepting edge.
- abort:
  - In CALC: go to IDLE at the next edge; busy=0; result, flags and DZ keep their previous values; no done.
  - abort and start together in IDLE/DONE: abort has priority; the request is not accepted.
- Outputs are registered; result, ZF, SF and DZ change only on a done-producing edge or on reset.

Test Plan:
- DIVU A=100, B=7 -> busy high for 32 cycles; done in cycle 33 after accept; result=14; ZF=0; SF=0.
- REM A=-7 (0xFFFFFFF9), B=2 -> result=0xFFFFFFFF (-1), SF=1. DIV with the same operands -> result=0xFFFFFFFD (-3).
- DIV A=0x80000000, B=0xFFFFFFFF -> done in the cycle after accept; result=0x80000000. REM with the same operands -> result=0, ZF=1.
- DIVU A=5, B=0 -> done in the cycle after accept; result=0xFFFFFFFF; DZ=1. REMU A=5, B=0 -> result=5; DZ=1.
- Back-to-back: DIVU 100/7, then start asserted in its done cycle with DIVU 9/3 -> second done exactly 33 cycles after the first; result=3. start pulses during busy produce no extra done.
- Abort and reset:
  - abort at iteration 10 of DIVU 100/7 -> IDLE next edge; no done; result keeps its prior value.
  - rst at iteration 20 -> busy=0, result=0, ZF=1 immediately (asynchronously).

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the RV32M divide group (DIV/DIVU/REM/REMU).
// One quotient bit per cycle; divide-by-zero and signed overflow resolve on the accept edge.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ZF,
  output logic             SF,
  output logic             DZ
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | shift/subtract iterations in progress, busy high
  // DONE  | result valid, done pulse; a new start is accepted here too
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic             sel_rem_q, sel_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             dz_q, dz_d;

  logic             is_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             b_zero, ovf;
  logic [WIDTH-1:0] sp_res;
  logic [WIDTH:0]   rem_sh;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] q_fin, r_fin, fin;
  logic             accept, load_res;

  assign is_signed = ~op[0];
  assign a_abs     = (is_signed && A[WIDTH-1]) ? -A : A;
  assign b_abs     = (is_signed && B[WIDTH-1]) ? -B : B;
  assign b_zero    = (B == '0);
  assign ovf       = is_signed && (A == MIN_NEG) && (B == '1);
  assign sp_res    = b_zero ? (op[1] ? A : '1) : (op[1] ? '0 : MIN_NEG);
  assign accept    = start && !abort && (state_q != S_CALC);

  // Partial remainder is one bit wider after the shift, so compare before subtracting.
  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign no_borrow = (rem_sh >= {1'b0, dvs_q});
  assign rem_step  = no_borrow ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], no_borrow};
  assign q_fin     = qneg_q ? -quo_step : quo_step;
  assign r_fin     = rneg_q ? -rem_step : rem_step;
  assign fin       = sel_rem_q ? r_fin : q_fin;

  always_comb begin
    state_d   = state_q;
    sel_rem_d = sel_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    dz_d      = dz_q;
    load_res  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          sel_rem_d = op[1];
          if (b_zero || ovf) begin
            state_d  = S_DONE;
            res_d    = sp_res;
            dz_d     = b_zero;
            load_res = 1'b1;
          end else begin
            state_d = S_CALC;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_d  = is_signed && A[WIDTH-1];
          end
        end
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          quo_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d  = S_DONE;
            res_d    = fin;
            dz_d     = 1'b0;
            load_res = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    zf_d = load_res ? (res_d == '0) : zf_q;
    sf_d = load_res ? res_d[WIDTH-1] : sf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_rem_q <= sel_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      dz_q      <= dz_d;
    end
  end

  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign ZF     = zf_q;
  assign SF     = sf_q;
  assign DZ     = dz_q;

endmodule
